// File: rtl/stream_mux_arb.sv
// Merges NUM_CH valid/ready streams onto one registered output stream.
// Channel choice is explicit via sel_i (MODE=0) or round-robin (MODE=1).
module stream_mux_arb #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        valid_i,
    output logic [NUM_CH-1:0]        ready_o,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [SEL_W-1:0]         grant_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [SEL_W-1:0]  grant_q;
    logic [SEL_W-1:0]  last_q;

    logic              out_free;
    logic              sel_valid;
    logic [SEL_W-1:0]  rr_hi_win;
    logic [SEL_W-1:0]  rr_lo_win;
    logic              rr_hi_ok;
    logic              rr_lo_ok;
    logic [SEL_W-1:0]  win;
    logic              win_ok;
    logic [DATA_W-1:0] win_data;
    logic              acc;

    assign out_free = !valid_q || ready_i;

    // An out-of-range sel_i matches no channel, so it can never be accepted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_valid = valid_i[k];
            end
        end
    end

    // Rotating priority: the lowest valid channel above last_q wins; otherwise
    // wrap around to the lowest valid channel at or below last_q.
    always_comb begin
        rr_hi_win = '0;
        rr_lo_win = '0;
        rr_hi_ok  = 1'b0;
        rr_lo_ok  = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (valid_i[j]) begin
                if (SEL_W'(j) > last_q) begin
                    rr_hi_win = SEL_W'(j);
                    rr_hi_ok  = 1'b1;
                end else begin
                    rr_lo_win = SEL_W'(j);
                    rr_lo_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (MODE == 0) begin
            win    = sel_i;
            win_ok = sel_valid;
        end else begin
            win    = rr_hi_ok ? rr_hi_win : rr_lo_win;
            win_ok = rr_hi_ok || rr_lo_ok;
        end
    end

    // In explicit mode the selected channel sees ready even when it is idle;
    // the arbiter offers ready only to a channel it actually picked.
    always_comb begin
        ready_o  = '0;
        win_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (win == SEL_W'(k)) begin
                ready_o[k] = out_free && ((MODE == 0) || win_ok);
                win_data   = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign acc = out_free && win_ok;

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            valid_q <= 1'b0;
            // NOTE: data_q is reset only because data_o must read 0 after reset; wide datapath flops normally skip reset.
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= SEL_W'(NUM_CH - 1);
        end else if (acc) begin
            data_q  <= win_data;
            grant_q <= win;
            valid_q <= 1'b1;
            last_q  <= win;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: explicit select (4 and 5 channels) and
// round-robin (4 channels); expected beats flow through a scoreboard queue.
module tb_stream_mux_arb;

    localparam logic [31:0] CH_DATA [5] = '{32'h0000_0005, 32'h0000_0011, 32'hAAAA_0002,
                                            32'h3333_3333, 32'h4444_4444};

    typedef struct {
        int         d;
        logic [4:0] valid;
        logic [2:0] sel;
        logic       rdy;
        logic [4:0] exp_ready;
        logic       exp_acc;
        logic [2:0] exp_grant;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  grant;
    } beat_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    // a: MODE=0, 4 channels; b: MODE=1, 4 channels; c: MODE=0, 5 channels
    logic [127:0] a_data_i, b_data_i;
    logic [159:0] c_data_i;
    logic [3:0]   a_valid_i = '0, a_ready_o, b_valid_i = '0, b_ready_o;
    logic [4:0]   c_valid_i = '0, c_ready_o;
    logic [1:0]   a_sel_i = '0, a_grant_o, b_sel_i = '0, b_grant_o;
    logic [2:0]   c_sel_i = '0, c_grant_o;
    logic [31:0]  a_data_o, b_data_o, c_data_o;
    logic         a_valid_o, b_valid_o, c_valid_o;
    logic         a_ready_i = 1'b0, b_ready_i = 1'b0, c_ready_i = 1'b0;

    assign a_data_i = {CH_DATA[3], CH_DATA[2], CH_DATA[1], CH_DATA[0]};
    assign b_data_i = {CH_DATA[3], CH_DATA[2], CH_DATA[1], CH_DATA[0]};
    assign c_data_i = {CH_DATA[4], CH_DATA[3], CH_DATA[2], CH_DATA[1], CH_DATA[0]};

    stream_mux_arb #(.DATA_W(32), .NUM_CH(4), .SEL_W(2), .MODE(0)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(a_data_i), .valid_i(a_valid_i),
        .ready_o(a_ready_o), .sel_i(a_sel_i), .data_o(a_data_o), .valid_o(a_valid_o),
        .ready_i(a_ready_i), .grant_o(a_grant_o));

    stream_mux_arb #(.DATA_W(32), .NUM_CH(4), .SEL_W(2), .MODE(1)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(b_data_i), .valid_i(b_valid_i),
        .ready_o(b_ready_o), .sel_i(b_sel_i), .data_o(b_data_o), .valid_o(b_valid_o),
        .ready_i(b_ready_i), .grant_o(b_grant_o));

    stream_mux_arb #(.DATA_W(32), .NUM_CH(5), .SEL_W(3), .MODE(0)) u_c (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(c_data_i), .valid_i(c_valid_i),
        .ready_o(c_ready_o), .sel_i(c_sel_i), .data_o(c_data_o), .valid_o(c_valid_o),
        .ready_i(c_ready_i), .grant_o(c_grant_o));

    int          n_cmp = 0;
    int          n_bad = 0;
    beat_t       sb_q[$];
    vec_t        tbl[$];
    logic [4:0]  cur_ready;
    logic [31:0] cur_data;
    logic        cur_valid;
    logic [2:0]  cur_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic [4:0] valid, input logic [2:0] sel, input logic rdy);
        case (d)
            0: begin a_valid_i = valid[3:0]; a_sel_i = sel[1:0]; a_ready_i = rdy; end
            1: begin b_valid_i = valid[3:0]; b_sel_i = sel[1:0]; b_ready_i = rdy; end
            default: begin c_valid_i = valid; c_sel_i = sel; c_ready_i = rdy; end
        endcase
    endtask

    task automatic sample(input int d);
        case (d)
            0: begin
                cur_ready = {1'b0, a_ready_o}; cur_data = a_data_o;
                cur_valid = a_valid_o;         cur_grant = {1'b0, a_grant_o};
            end
            1: begin
                cur_ready = {1'b0, b_ready_o}; cur_data = b_data_o;
                cur_valid = b_valid_o;         cur_grant = {1'b0, b_grant_o};
            end
            default: begin
                cur_ready = c_ready_o; cur_data = c_data_o;
                cur_valid = c_valid_o; cur_grant = c_grant_o;
            end
        endcase
    endtask

    // One clock: drive at negedge, check mid-low-phase, predict the next beat.
    task automatic cycle(input int d, input logic [4:0] valid, input logic [2:0] sel, input logic rdy,
                         input logic [4:0] exp_ready, input logic exp_acc, input logic [2:0] exp_grant,
                         input string name);
        beat_t b;
        @(negedge clk_i);
        drive(d, valid, sel, rdy);
        #1;
        sample(d);
        check({name, " ready_o"}, 32'(cur_ready), 32'(exp_ready));
        check({name, " valid_o"}, 32'(cur_valid), 32'(sb_q.size() != 0));
        if (cur_valid && sb_q.size() != 0) begin
            if (rdy) b = sb_q.pop_front();
            else     b = sb_q[0];
            check({name, " data_o"},  cur_data,         b.data);
            check({name, " grant_o"}, 32'(cur_grant),   32'(b.grant));
        end
        if (exp_acc) sb_q.push_back('{data: CH_DATA[exp_grant], grant: exp_grant});
    endtask

    function automatic vec_t mk(int d, logic [4:0] v, logic [2:0] s, logic r,
                                logic [4:0] er, logic ea, logic [2:0] eg);
        vec_t t;
        t.d = d; t.valid = v; t.sel = s; t.rdy = r;
        t.exp_ready = er; t.exp_acc = ea; t.exp_grant = eg;
        return t;
    endfunction

    initial begin
        // explicit select, 4 channels: sel=3 beats ch1, stall, drain+accept overlap
        tbl.push_back(mk(0, 5'b01010, 3'd3, 1'b1, 5'b01000, 1'b1, 3'd3));
        tbl.push_back(mk(0, 5'b00000, 3'd3, 1'b1, 5'b01000, 1'b0, 3'd0));
        tbl.push_back(mk(0, 5'b00010, 3'd1, 1'b0, 5'b00010, 1'b1, 3'd1));
        tbl.push_back(mk(0, 5'b00010, 3'd1, 1'b0, 5'b00000, 1'b0, 3'd0));
        tbl.push_back(mk(0, 5'b00001, 3'd0, 1'b1, 5'b00001, 1'b1, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 3'd2, 1'b1, 5'b00100, 1'b0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 3'd2, 1'b1, 5'b00100, 1'b0, 3'd0));
        // round-robin fairness, all channels valid
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 5'b01111, 3'd0, 1'b1, 5'(1 << (i % 4)), 1'b1, 3'(i % 4)));
        end
        tbl.push_back(mk(1, 5'b00000, 3'd0, 1'b1, 5'b00000, 1'b0, 3'd0));
        // sparse round-robin: ch0/ch2 alternate
        tbl.push_back(mk(1, 5'b00101, 3'd0, 1'b1, 5'b00001, 1'b1, 3'd0));
        tbl.push_back(mk(1, 5'b00101, 3'd0, 1'b1, 5'b00100, 1'b1, 3'd2));
        tbl.push_back(mk(1, 5'b00101, 3'd0, 1'b1, 5'b00001, 1'b1, 3'd0));
        tbl.push_back(mk(1, 5'b00101, 3'd0, 1'b1, 5'b00100, 1'b1, 3'd2));
        tbl.push_back(mk(1, 5'b00000, 3'd0, 1'b1, 5'b00000, 1'b0, 3'd0));

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            sample(d);
            check($sformatf("reset dut%0d valid_o", d), 32'(cur_valid), 32'd0);
            check($sformatf("reset dut%0d data_o", d),  cur_data,       32'd0);
            check($sformatf("reset dut%0d grant_o", d), 32'(cur_grant), 32'd0);
        end

        foreach (tbl[i]) begin
            cycle(tbl[i].d, tbl[i].valid, tbl[i].sel, tbl[i].rdy, tbl[i].exp_ready,
                  tbl[i].exp_acc, tbl[i].exp_grant, $sformatf("vec%0d", i));
        end

        // backpressure: ch1 held for 3 stalled cycles, then ch3 wins after last_q=1
        cycle(1, 5'b00010, 3'd0, 1'b1, 5'b00010, 1'b1, 3'd1, "bp load");
        for (int i = 0; i < 3; i++) begin
            cycle(1, 5'b01010, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0, $sformatf("bp stall%0d", i));
        end
        cycle(1, 5'b01010, 3'd0, 1'b1, 5'b01000, 1'b1, 3'd3, "bp resume");
        cycle(1, 5'b00000, 3'd0, 1'b1, 5'b00000, 1'b0, 3'd0, "bp drain");

        // reset mid-stream drops the held ch2 word and restores channel-0 priority
        cycle(1, 5'b00100, 3'd0, 1'b0, 5'b00100, 1'b1, 3'd2, "rst load");
        cycle(1, 5'b00000, 3'd0, 1'b0, 5'b00000, 1'b0, 3'd0, "rst hold");
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        sample(1);
        check("midrst valid_o", 32'(cur_valid), 32'd0);
        check("midrst data_o",  cur_data,       32'd0);
        check("midrst grant_o", 32'(cur_grant), 32'd0);
        sb_q.delete();
        cycle(1, 5'b01111, 3'd0, 1'b1, 5'b00001, 1'b1, 3'd0, "rst first grant");
        cycle(1, 5'b01111, 3'd0, 1'b1, 5'b00010, 1'b1, 3'd1, "rst second grant");
        cycle(1, 5'b00000, 3'd0, 1'b1, 5'b00000, 1'b0, 3'd0, "rst drain");

        // 5 channels: drain holds data, out-of-range selects never accept
        cycle(2, 5'b00001, 3'd0, 1'b1, 5'b00001, 1'b1, 3'd0, "c load");
        cycle(2, 5'b11111, 3'd5, 1'b1, 5'b00000, 1'b0, 3'd0, "c sel5");
        cycle(2, 5'b11111, 3'd5, 1'b1, 5'b00000, 1'b0, 3'd0, "c sel5 idle");
        check("c drain hold data_o", cur_data, 32'h0000_0005);
        cycle(2, 5'b10000, 3'd4, 1'b1, 5'b10000, 1'b1, 3'd4, "c sel4");
        cycle(2, 5'b11111, 3'd7, 1'b1, 5'b00000, 1'b0, 3'd0, "c sel7");
        cycle(2, 5'b00000, 3'd6, 1'b1, 5'b00000, 1'b0, 3'd0, "c sel6");
        check("c hold data_o",  cur_data,       32'h4444_4444);
        check("c hold grant_o", 32'(cur_grant), 32'd4);

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
